// File: rtl/vga_draw_arbiter.sv
// Single-owner arbiter for the shared VGA adapter pixel-write port; forwards the owner's pixel stream through one register stage.
// Define VGA_ARB_FIXED_PRIORITY_EN to select the lowest-index requester instead of round-robin.
module vga_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     plot_in,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*C_W-1:0] colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot
);

`ifdef VGA_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [2:0]         r_ptr, w_ptr_next;
    logic [2:0]         r_owner, w_owner_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic               r_busy, w_busy_next;
    logic               r_vga_plot, w_plot_next;
    logic [X_W-1:0]     r_vga_x, w_x_next;
    logic [Y_W-1:0]     r_vga_y, w_y_next;
    logic [C_W-1:0]     r_vga_colour, w_colour_next;

    // Requester lanes padded to 8 so a 3-bit owner index always selects a real entry.
    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_plot_ext;
    logic [X_W-1:0]     w_x_arr      [MAX_REQ];
    logic [Y_W-1:0]     w_y_arr      [MAX_REQ];
    logic [C_W-1:0]     w_colour_arr [MAX_REQ];

    logic [2:0]         w_scan_base;
    logic [2:0]         w_sel;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [2:0]         w_owner_inc;
    logic               w_own_req;
    logic               w_own_plot;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_lane
            if (gi < NUM_REQ) begin : g_real
                assign w_req_ext[gi]    = req[gi];
                assign w_plot_ext[gi]   = plot_in[gi];
                assign w_x_arr[gi]      = x_in[gi*X_W +: X_W];
                assign w_y_arr[gi]      = y_in[gi*Y_W +: Y_W];
                assign w_colour_arr[gi] = colour_in[gi*C_W +: C_W];
            end else begin : g_pad
                assign w_req_ext[gi]    = 1'b0;
                assign w_plot_ext[gi]   = 1'b0;
                assign w_x_arr[gi]      = '0;
                assign w_y_arr[gi]      = '0;
                assign w_colour_arr[gi] = '0;
            end
        end

        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (w_sel == 3'(gi));
        end
    endgenerate

    assign w_scan_base = FIXED_PRIO ? 3'd0 : r_ptr;
    assign w_owner_inc = (r_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_owner + 3'd1;
    assign w_own_req   = w_req_ext[r_owner];
    assign w_own_plot  = w_plot_ext[r_owner];

    // Scan from the far end back toward the base so the nearest set bit is written last.
    always_comb begin
        logic [3:0] w_scan_idx;
        w_sel      = 3'd0;
        w_scan_idx = 4'd0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_scan_idx = {1'b0, w_scan_base} + 4'(off);
            if (w_scan_idx >= 4'(NUM_REQ))
                w_scan_idx = w_scan_idx - 4'(NUM_REQ);
            if (w_req_ext[w_scan_idx[2:0]])
                w_sel = w_scan_idx[2:0];
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_owner_next  = r_owner;
        w_grant_next  = r_grant;
        w_busy_next   = r_busy;
        w_plot_next   = 1'b0;
        w_x_next      = r_vga_x;
        w_y_next      = r_vga_y;
        w_colour_next = r_vga_colour;

        case (r_state)
            ST_IDLE: begin
                w_grant_next = '0;
                w_busy_next  = 1'b0;
                if (|req) begin
                    w_state_next = ST_OWN;
                    w_grant_next = w_sel_onehot;
                    w_owner_next = w_sel;
                    w_busy_next  = 1'b1;
                end
            end
            ST_OWN: begin
                w_busy_next   = 1'b1;
                w_x_next      = w_x_arr[r_owner];
                w_y_next      = w_y_arr[r_owner];
                w_colour_next = w_colour_arr[r_owner];
                if (w_own_req) begin
                    w_plot_next = w_own_plot;
                end else begin
                    // Burst over: the pointer moves past this owner so it cannot win immediately again.
                    w_state_next = ST_RELEASE;
                    w_grant_next = '0;
                    w_ptr_next   = FIXED_PRIO ? 3'd0 : w_owner_inc;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 3'd0;
            r_owner      <= 3'd0;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_vga_plot   <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_owner      <= w_owner_next;
            r_grant      <= w_grant_next;
            r_busy       <= w_busy_next;
            r_vga_plot   <= w_plot_next;
            r_vga_x      <= w_x_next;
            r_vga_y      <= w_y_next;
            r_vga_colour <= w_colour_next;
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign owner      = r_owner;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: emulated drawing engines, a burst-level reference model and a decoupled monitor.
module tb_vga_draw_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
`ifdef VGA_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  plot_in = '0;
    logic [N*XW-1:0] x_in = '0;
    logic [N*YW-1:0] y_in = '0;
    logic [N*CW-1:0] colour_in = '0;
    logic [N-1:0]  grant;
    logic          busy;
    logic [2:0]    owner;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    vga_draw_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .grant(grant), .busy(busy), .owner(owner),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic          busy;
        logic [2:0]    owner;
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } stat_t;
    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    stat_t stat_q[$];
    pix_t  pix_q[$];
    int checks = 0;
    int errors = 0;
    int n_plots = 0;
    int obs_n = 0;
    int obs_gap = 0;
    int obs_order[256];

    // Engine emulation state
    bit e_active[N], e_pend[N], e_dense[N], e_noise[N], e_fixed[N];
    int e_rem[N], e_len[N], e_restart[N];
    logic [XW-1:0] e_x[N];
    logic [YW-1:0] e_y[N];
    logic [CW-1:0] e_c[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: burst-level view of ownership, evaluated on each clock edge.
    initial begin : model
        int m_owner, m_ptr, m_last, pick, idx;
        bit m_rel, m_plot;
        logic [XW-1:0] m_x;
        logic [YW-1:0] m_y;
        logic [CW-1:0] m_c;
        stat_t s;
        pix_t p;
        m_owner = -1; m_ptr = 0; m_last = 0; m_rel = 0; m_plot = 0;
        m_x = '0; m_y = '0; m_c = '0;
        forever begin
            @(posedge clk);
            m_plot = 0;
            if (!resetn) begin
                m_owner = -1; m_ptr = 0; m_last = 0; m_rel = 0;
                m_x = '0; m_y = '0; m_c = '0;
            end else if (m_owner >= 0) begin
                m_x = x_in[m_owner*XW +: XW];
                m_y = y_in[m_owner*YW +: YW];
                m_c = colour_in[m_owner*CW +: CW];
                if (req[m_owner]) begin
                    m_plot = plot_in[m_owner];
                    if (m_plot) begin
                        p.x = m_x; p.y = m_y; p.c = m_c;
                        pix_q.push_back(p);
                    end
                end else begin
                    m_ptr   = FIXED ? 0 : (m_owner + 1) % N;
                    m_owner = -1;
                    m_rel   = 1;
                end
            end else if (m_rel) begin
                m_rel = 0;
            end else if (req != 0) begin
                pick = -1;
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (pick < 0 && req[idx]) pick = idx;
                end
                m_owner = pick;
                m_last  = pick;
            end
            s.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            s.busy  = (m_owner >= 0) || m_rel;
            s.owner = 3'(m_last);
            s.plot  = m_plot;
            s.x = m_x; s.y = m_y; s.c = m_c;
            stat_q.push_back(s);
        end
    end

    // Monitor: compares DUT outputs against the model's queues after every edge.
    initial begin : monitor
        stat_t e;
        pix_t p;
        int zrun, gi;
        logic [N-1:0] prev;
        zrun = 0; prev = '0;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (stat_q.size() == 0) begin
                errors++;
                $display("FAIL status_queue: got empty queue expected one entry");
            end else begin
                e = stat_q.pop_front();
                if (grant !== e.grant || busy !== e.busy || owner !== e.owner || vga_plot !== e.plot ||
                    vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
                    errors++;
                    $display("FAIL cycle_status t=%0t: got grant=%b busy=%b owner=%0d plot=%b x=%0d y=%0d c=%0d expected grant=%b busy=%b owner=%0d plot=%b x=%0d y=%0d c=%0d",
                             $time, grant, busy, owner, vga_plot, vga_x, vga_y, vga_colour,
                             e.grant, e.busy, e.owner, e.plot, e.x, e.y, e.c);
                end
            end
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL grant_onehot: got %b expected at most one bit", grant);
            end
            if (vga_plot === 1'b1) begin
                n_plots++;
                checks++;
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d expected no plot", vga_x, vga_y, vga_colour);
                end else begin
                    p = pix_q.pop_front();
                    if (vga_x !== p.x || vga_y !== p.y || vga_colour !== p.c) begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                    end
                end
            end
            if (grant != '0 && prev == '0) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                obs_order[obs_n % 256] = gi;
                obs_n++;
                obs_gap = zrun;
            end
            zrun = (grant == '0) ? zrun + 1 : 0;
            prev = grant;
        end
    end

    task automatic step();
        logic r, p;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (e_pend[i]) begin
                e_pend[i] = 0; e_active[i] = 1; e_rem[i] = e_len[i];
            end
            r = 1'b0; p = 1'b0;
            if (!resetn) begin
                e_active[i] = 0; e_pend[i] = 0; e_restart[i] = 0;
            end else if (!e_active[i]) begin
                p = e_noise[i] ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (!grant[i]) begin
                r = 1'b1; p = 1'($urandom_range(0, 1));
            end else if (e_rem[i] > 0) begin
                r = 1'b1;
                p = e_dense[i] ? 1'b1 : 1'($urandom_range(0, 1));
                if (p) e_rem[i]--;
            end else begin
                e_active[i] = 0;
                if (e_restart[i] > 0) begin
                    e_restart[i]--; e_pend[i] = 1;
                end
            end
            req[i] = r;
            plot_in[i] = p;
            x_in[i*XW +: XW]      = e_fixed[i] ? e_x[i] : 8'($urandom_range(0, 159));
            y_in[i*YW +: YW]      = e_fixed[i] ? e_y[i] : 7'($urandom_range(0, 119));
            colour_in[i*CW +: CW] = e_fixed[i] ? e_c[i] : 3'($urandom_range(0, 7));
        end
    endtask

    task automatic start_eng(input int i, input int len, input bit dense, input int restarts);
        e_active[i] = 1; e_rem[i] = len; e_len[i] = len; e_dense[i] = dense; e_restart[i] = restarts;
    endtask

    function automatic bit engines_idle();
        for (int i = 0; i < N; i++) if (e_active[i] || e_pend[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = engines_idle() && !busy && grant == '0;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_grant(input string name, input int i, input int budget);
        int n;
        n = 0;
        while (!grant[i] && n < budget) begin
            step();
            n++;
        end
        if (!grant[i]) chk({name, "_grant_timeout"}, 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) step();
        resetn = 1'b1;
    endtask

    initial begin : stimulus
        int o0, p0;
        for (int i = 0; i < N; i++) begin
            e_active[i] = 0; e_pend[i] = 0; e_dense[i] = 0; e_noise[i] = 0; e_fixed[i] = 0;
            e_rem[i] = 0; e_len[i] = 0; e_restart[i] = 0;
            e_x[i] = '0; e_y[i] = '0; e_c[i] = '0;
        end
        do_reset(3);
        chk("reset_grant", int'(grant), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_owner", int'(owner), 0);
        chk("reset_plot", int'(vga_plot), 0);
        chk("reset_x", int'(vga_x), 0);

        // Single one-pixel burst with known coordinates
        e_fixed[1] = 1; e_x[1] = 8'd25; e_y[1] = 7'd40; e_c[1] = 3'b100;
        o0 = obs_n; p0 = n_plots;
        start_eng(1, 1, 1, 0);
        wait_idle("tp1", 50);
        chk("tp1_first_owner", obs_order[o0 % 256], 1);
        chk("tp1_plots", n_plots - p0, 1);
        chk("tp1_vga_x", int'(vga_x), 25);
        chk("tp1_vga_y", int'(vga_y), 40);
        chk("tp1_vga_colour", int'(vga_colour), 4);
        chk("tp1_owner", int'(owner), 1);
        e_fixed[1] = 0;

        // Two simultaneous requesters from a fresh pointer
        do_reset(2);
        o0 = obs_n; p0 = n_plots;
        start_eng(0, 3, 1, 0);
        start_eng(2, 3, 1, 0);
        wait_idle("tp2", 80);
        chk("tp2_grants", obs_n - o0, 2);
        chk("tp2_order0", obs_order[o0 % 256], 0);
        chk("tp2_order1", obs_order[(o0 + 1) % 256], 2);
        chk("tp2_plots", n_plots - p0, 6);
        chk("tp2_gap", obs_gap, 2);

        // Pointer wrap after owner 3
        o0 = obs_n;
        start_eng(3, 3, 1, 0);
        wait_grant("tp3", 3, 20);
        start_eng(0, 2, 1, 0);
        wait_idle("tp3a", 80);
        chk("tp3_order0", obs_order[o0 % 256], 3);
        chk("tp3_order1", obs_order[(o0 + 1) % 256], 0);
        o0 = obs_n;
        start_eng(0, 2, 1, 0);
        start_eng(3, 2, 1, 0);
        wait_idle("tp3b", 80);
        chk("tp3_both_first", obs_order[o0 % 256], FIXED ? 0 : 3);
        chk("tp3_both_second", obs_order[(o0 + 1) % 256], FIXED ? 3 : 0);

        // Non-owner plot strobes must be ignored
        e_noise[2] = 1;
        e_fixed[1] = 1; e_x[1] = 8'd10; e_y[1] = 7'd20; e_c[1] = 3'd5;
        p0 = n_plots;
        start_eng(1, 5, 1, 0);
        wait_idle("tp4", 80);
        e_noise[2] = 0; e_fixed[1] = 0;
        chk("tp4_plots", n_plots - p0, 5);
        chk("tp4_vga_x", int'(vga_x), 10);
        chk("tp4_owner", int'(owner), 1);

        // Reset in the middle of a 10-pixel burst
        start_eng(3, 10, 1, 0);
        wait_grant("tp5", 3, 20);
        repeat (4) step();
        resetn = 1'b0;
        step();
        chk("tp5_grant", int'(grant), 0);
        chk("tp5_plot", int'(vga_plot), 0);
        chk("tp5_busy", int'(busy), 0);
        resetn = 1'b1;
        o0 = obs_n;
        start_eng(1, 2, 1, 0);
        start_eng(3, 2, 1, 0);
        wait_idle("tp5b", 80);
        chk("tp5_restart_first", obs_order[o0 % 256], 1);
        chk("tp5_restart_second", obs_order[(o0 + 1) % 256], 3);

        // Requester 1 keeps re-requesting against requester 2
        o0 = obs_n;
        start_eng(1, 2, 1, 3);
        start_eng(2, 2, 1, 3);
        wait_idle("tp6", 300);
        chk("tp6_grants", obs_n - o0, 8);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tp6_order%0d", i), obs_order[(o0 + i) % 256], FIXED ? 1 : ((i % 2 == 0) ? 1 : 2));

        // Random traffic
        for (int i = 0; i < N; i++) e_noise[i] = 1;
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!e_active[i] && !e_pend[i] && $urandom_range(0, 7) == 0)
                    start_eng(i, $urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < N; i++) e_noise[i] = 0;
        wait_idle("random_drain", 1000);
        chk("pixel_queue_drained", pix_q.size(), 0);
        chk("status_queue_drained", stat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
